// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM request/response, decoder valid/ready and execute-stage redirect.
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_rdata;
    logic                  rom_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output rom_en, rom_addr, instr, pc, instr_valid,
        input  rom_rdata, rom_valid, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  rom_en, rom_addr, instr, pc, instr_valid,
        output rom_rdata, rom_valid, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single-outstanding ROM reads, registered
// instr/pc handoff to decode, and redirect with in-flight fetch discard.
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  flush_q, flush_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0] redir_target;

    assign redir_target = bus.redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        flush_d       = flush_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        bus.rom_en    = 1'b0;
        unique case (state_q)
            REQ: begin
                bus.rom_en = !bus.redirect;
                if (bus.redirect) begin
                    fetch_pc_d = redir_target;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect coinciding with the response drops the word
                // immediately, so no flush needs to be remembered.
                if (bus.rom_valid && bus.redirect) begin
                    flush_d    = 1'b0;
                    fetch_pc_d = redir_target;
                    state_d    = REQ;
                end else if (bus.rom_valid) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d       = bus.rom_rdata;
                        pc_d          = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (bus.redirect) begin
                    fetch_pc_d = redir_target;
                    flush_d    = 1'b1;
                end
            end
            HOLD: begin
                if (bus.redirect || bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    fetch_pc_d    = bus.redirect ? redir_target
                                                 : fetch_pc_q + ADDR_WIDTH'(4);
                    state_d       = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            fetch_pc_q    <= RESET_PC;
            flush_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            flush_q       <= flush_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = instr_valid_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, corner-case sequences and a
// randomized run checked against a fetch-stream reference model.
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic rst2;

    instr_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    instr_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

    instr_fetch #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    instr_fetch #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)
    ) dut_wrap (.clk(clk), .rst(rst2), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // ROM response model state
    bit          pend;
    int          rem;
    logic [31:0] raddr;
    int          lat_min, lat_max;
    bit          spur_en;

    // sampled DUT outputs
    logic        o_en, o_valid;
    logic [31:0] o_addr, o_instr, o_pc;

    typedef struct {
        bit          rdy;
        bit          rd;
        logic [31:0] rpc;
        bit          e_en;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          chk_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic addv(input bit rdy, input bit rd, input logic [31:0] rpc,
                        input bit e_en, input logic [31:0] e_addr, input bit e_valid,
                        input logic [31:0] e_instr, input logic [31:0] e_pc, input bit chk_pc);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.e_en = e_en; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc; v.chk_pc = chk_pc;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive inputs, let combinational rom_en settle, sample,
    // then advance the ROM model as the DUT's rising edge will see it.
    task automatic cyc(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        rst             = r;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        if (pend && rem == 1) begin
            bus.rom_valid = 1'b1;
            bus.rom_rdata = rom_word(raddr);
        end else if (!pend && spur_en && $urandom_range(0, 9) == 0) begin
            bus.rom_valid = 1'b1;
            bus.rom_rdata = $urandom;
        end else begin
            bus.rom_valid = 1'b0;
            bus.rom_rdata = $urandom;
        end
        #1;
        o_en    = bus.rom_en;
        o_addr  = bus.rom_addr;
        o_valid = bus.instr_valid;
        o_instr = bus.instr;
        o_pc    = bus.pc;
        if (r) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                rem--;
                if (rem == 0) pend = 1'b0;
            end
            if (o_en === 1'b1) begin
                chk("one_outstanding", 32'(pend), 32'd0);
                pend  = 1'b1;
                rem   = $urandom_range(lat_min, lat_max);
                raddr = o_addr;
            end
        end
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            n++;
        end while (o_valid !== 1'b1 && n < 12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] exp_pc, prev_instr, prev_pc, rpc;
        bit          prev_valid, prev_hold, r, rdy, rd;
        int          delivered;

        rst = 1'b1; rst2 = 1'b1;
        bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.rom_valid = 1'b0; bus.rom_rdata = '0;
        bus2.instr_ready = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = '0;
        bus2.rom_valid = 1'b0; bus2.rom_rdata = '0;
        pend = 1'b0; rem = 0; raddr = '0; spur_en = 1'b0;
        lat_min = 1; lat_max = 1;

        // ---- directed table, L=1 ----
        addv(1, 0, 0,      1, 32'h0,   0, NOP, 32'h0, 1);
        addv(1, 0, 0,      0, 0,       0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       1, rom_word(32'h0), 32'h0, 1);
        addv(1, 0, 0,      1, 32'h4,   0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       0, NOP, 0, 0);
        for (int i = 0; i < 5; i++)
            addv(0, 0, 0,  0, 0,       1, rom_word(32'h4), 32'h4, 1);
        addv(1, 0, 0,      0, 0,       1, rom_word(32'h4), 32'h4, 1);
        addv(1, 0, 0,      1, 32'h8,   0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       0, NOP, 0, 0);
        addv(0, 0, 0,      0, 0,       1, rom_word(32'h8), 32'h8, 1);
        addv(1, 0, 0,      0, 0,       1, rom_word(32'h8), 32'h8, 1);
        addv(1, 1, 32'h202, 0, 0,      0, NOP, 0, 0);
        addv(1, 0, 0,      1, 32'h200, 0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       0, NOP, 0, 0);
        addv(0, 1, 32'h41, 0, 0,       1, rom_word(32'h200), 32'h200, 1);
        addv(1, 0, 0,      1, 32'h40,  0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       0, NOP, 0, 0);
        addv(1, 0, 0,      0, 0,       1, rom_word(32'h40), 32'h40, 1);

        do_reset();
        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            chk($sformatf("tbl%0d_en", i), 32'(o_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_instr", i), o_instr, tbl[i].e_instr);
            if (tbl[i].chk_pc) chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].e_pc);
        end

        // ---- redirect while waiting, L=3 ----
        lat_min = 3; lat_max = 3;
        do_reset();
        cyc(0, 1, 0, 0);         chk("rw_en0", 32'(o_en), 1); chk("rw_addr0", o_addr, 0);
        cyc(0, 1, 1, 32'h103);   chk("rw_en1", 32'(o_en), 0); chk("rw_v1", 32'(o_valid), 0);
        cyc(0, 1, 0, 0);         chk("rw_v2", 32'(o_valid), 0);
        cyc(0, 1, 0, 0);         chk("rw_v3", 32'(o_valid), 0);
        cyc(0, 1, 0, 0);         chk("rw_en4", 32'(o_en), 1); chk("rw_addr4", o_addr, 32'h100);
                                 chk("rw_v4", 32'(o_valid), 0);
        wait_valid(n);           chk("rw_lat", n, 4); chk("rw_pc", o_pc, 32'h100);
                                 chk("rw_instr", o_instr, rom_word(32'h100));

        // ---- redirect coinciding with rom_valid, L=2 ----
        lat_min = 2; lat_max = 2;
        do_reset();
        cyc(0, 1, 0, 0);         chk("rv_en0", 32'(o_en), 1);
        cyc(0, 1, 0, 0);         chk("rv_en1", 32'(o_en), 0);
        cyc(0, 1, 1, 32'h80);    chk("rv_en2", 32'(o_en), 0);
        cyc(0, 1, 0, 0);         chk("rv_en3", 32'(o_en), 1); chk("rv_addr3", o_addr, 32'h80);
                                 chk("rv_v3", 32'(o_valid), 0);
        wait_valid(n);           chk("rv_lat", n, 3); chk("rv_pc", o_pc, 32'h80);

        // ---- reset in WAIT, L=3 ----
        lat_min = 3; lat_max = 3;
        do_reset();
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);         chk("rs_v", 32'(o_valid), 0); chk("rs_instr", o_instr, NOP);
                                 chk("rs_en", 32'(o_en), 1); chk("rs_addr", o_addr, 32'h0);
        wait_valid(n);           chk("rs_lat", n, 4); chk("rs_pc", o_pc, 32'h0);
                                 chk("rs_instr2", o_instr, rom_word(32'h0));

        // ---- PC wrap on the second instance, L=1 ----
        @(negedge clk); rst2 = 1'b1;
        @(negedge clk); rst2 = 1'b0; bus2.instr_ready = 1'b1;
        #1; chk("wr_en0", 32'(bus2.rom_en), 1); chk("wr_addr0", bus2.rom_addr, 32'hFFFF_FFFC);
            chk("wr_pc0", bus2.pc, 32'hFFFF_FFFC);
        @(negedge clk); bus2.rom_valid = 1'b1; bus2.rom_rdata = rom_word(32'hFFFF_FFFC);
        #1; chk("wr_v1", 32'(bus2.instr_valid), 0);
        @(negedge clk); bus2.rom_valid = 1'b0;
        #1; chk("wr_v2", 32'(bus2.instr_valid), 1); chk("wr_pc2", bus2.pc, 32'hFFFF_FFFC);
        @(negedge clk);
        #1; chk("wr_en3", 32'(bus2.rom_en), 1); chk("wr_addr3", bus2.rom_addr, 32'h0);

        // ---- randomized run against the fetch-stream model ----
        lat_min = 1; lat_max = 4; spur_en = 1'b1;
        do_reset();
        exp_pc = 32'h0; prev_valid = 0; prev_hold = 0; prev_instr = '0; prev_pc = '0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 'h3FF));
            cyc(r, rdy, rd, rpc);
            if (o_valid === 1'b1 && !prev_valid) begin
                chk("rnd_pc", o_pc, exp_pc);
                chk("rnd_instr", o_instr, rom_word(o_pc));
                delivered++;
            end
            if (prev_hold) begin
                chk("rnd_hold_v", 32'(o_valid), 1);
                chk("rnd_hold_instr", o_instr, prev_instr);
                chk("rnd_hold_pc", o_pc, prev_pc);
            end
            if (o_valid !== 1'b1) chk("rnd_nop", o_instr, NOP);
            else                  chk("rnd_en_hold", 32'(o_en), 0);
            if (r) begin
                exp_pc = 32'h0;
            end else begin
                if (o_valid === 1'b1 && rdy) exp_pc = o_pc + 32'd4;
                if (rd) exp_pc = rpc & ~32'd3;
            end
            prev_valid = (o_valid === 1'b1);
            prev_hold  = prev_valid && !rdy && !rd && !r;
            prev_instr = o_instr;
            prev_pc    = o_pc;
        end
        chk("rnd_delivered", 32'(delivered >= 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
